// File: rtl/axil_reg_rd_pipe_if.sv
// AXI-Lite read-channel bundle (AR + R) between an interconnect master and a register-read slave.
interface axil_reg_rd_pipe_if #(
  parameter int ADDR_WIDTH = 40,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output araddr, arprot, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arprot, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_reg_rd_pipe.sv
// AXI-Lite read slave bridged to a wait/ack register-read port, with an in-order response FIFO.
// Optional address window decode (DECERR outside the window) enabled by AXIL_RD_ADDR_CHECK_EN.
module axil_reg_rd_pipe #(
  parameter int              DATA_WIDTH = 32,
  parameter int              ADDR_WIDTH = 40,
  parameter int              RESP_DEPTH = 4,
  parameter int              TIMEOUT    = 16,
  parameter longint unsigned BASE_ADDR  = 0,
  parameter longint unsigned SPAN_BYTES = 4096
) (
  input  logic                  clk,
  input  logic                  rstn,
  axil_reg_rd_pipe_if.slave     s_axil,
  output logic [ADDR_WIDTH-1:0] reg_rd_addr,
  output logic                  reg_rd_en,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  input  logic                  reg_rd_wait,
  input  logic                  reg_rd_ack,
  output logic                  rd_timeout
);
  localparam int PTR_W = $clog2(RESP_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CRD_W = CNT_W + 1;
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

`ifdef AXIL_RD_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  // One extra bit so BASE_ADDR + SPAN_BYTES cannot wrap
  localparam logic [ADDR_WIDTH:0] WIN_LO = (ADDR_WIDTH+1)'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0] WIN_HI = WIN_LO + (ADDR_WIDTH+1)'(SPAN_BYTES);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state;
  logic                  hold_valid;
  logic [ADDR_WIDTH-1:0] hold_addr;
  logic [TMO_W-1:0]      tmo_cnt;

  logic [DATA_WIDTH-1:0] fifo_data [RESP_DEPTH];
  logic [1:0]            fifo_resp [RESP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;

  logic                  ar_hs;
  logic                  src_valid;
  logic [ADDR_WIDTH-1:0] src_addr;
  logic [CRD_W-1:0]      credit;
  logic                  credit_ok;
  logic                  issue;
  logic                  in_win;
  logic                  dec_err;
  logic                  tmo_fire;
  logic                  done;
  logic                  push;
  logic [DATA_WIDTH-1:0] push_data;
  logic [1:0]            push_resp;
  logic                  pop;

  // An AR arriving while IDLE with an empty hold issues directly, giving one-cycle AR->reg_rd_en
  assign ar_hs     = s_axil.arvalid && !hold_valid;
  assign src_valid = hold_valid || ar_hs;
  assign src_addr  = hold_valid ? hold_addr : s_axil.araddr;

  assign credit    = CRD_W'(count) + CRD_W'(state == BUSY);
  assign credit_ok = credit < CRD_W'(RESP_DEPTH);
  assign issue     = (state == IDLE) && src_valid && credit_ok;

  assign in_win    = ({1'b0, src_addr} >= WIN_LO) && ({1'b0, src_addr} < WIN_HI);
  assign dec_err   = ADDR_CHECK && !in_win;

  assign tmo_fire  = (TIMEOUT != 0) && (tmo_cnt == '0) && !reg_rd_wait;
  assign done      = (state == BUSY) && (reg_rd_ack || tmo_fire);

  assign push      = done || (issue && dec_err);
  assign push_data = (done && reg_rd_ack) ? reg_rd_data : '0;
  assign push_resp = !done ? RESP_DECERR : (reg_rd_ack ? RESP_OKAY : RESP_SLVERR);

  assign s_axil.arready = !hold_valid;
  assign s_axil.rvalid  = (count != '0);
  assign s_axil.rdata   = s_axil.rvalid ? fifo_data[rd_ptr] : '0;
  assign s_axil.rresp   = s_axil.rvalid ? fifo_resp[rd_ptr] : RESP_OKAY;
  assign pop            = s_axil.rvalid && s_axil.rready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      hold_valid  <= 1'b0;
      reg_rd_en   <= 1'b0;
      reg_rd_addr <= '0;
      tmo_cnt     <= '0;
      rd_timeout  <= 1'b0;
    end else begin
      rd_timeout <= 1'b0;
      if (issue)      hold_valid <= 1'b0;
      else if (ar_hs) hold_valid <= 1'b1;

      case (state)
        IDLE: begin
          if (issue && !dec_err) begin
            reg_rd_en   <= 1'b1;
            reg_rd_addr <= src_addr;
            tmo_cnt     <= TMO_LOAD;
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (done) begin
            reg_rd_en  <= 1'b0;
            rd_timeout <= !reg_rd_ack;
            state      <= IDLE;
          end else if (!reg_rd_wait && tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (ar_hs && !issue) hold_addr <= s_axil.araddr;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= push_data;
      fifo_resp[wr_ptr] <= push_resp;
    end
  end
endmodule
